// File: rtl/multi_chan_block_regs.sv
// Per-channel register bank: global page plus NUM_CHAN channel windows of 32 words.
// W1C sticky status, atomic 56-bit sample index, reload strobes with word counter, masked irq.
module multi_chan_block_regs #(
  parameter int unsigned NUM_CHAN   = 4,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter logic [15:0] BLK_ID     = 16'h0003,
  parameter logic [15:0] BLK_VER    = 16'h0001
) (
  input  logic                     user_clk,
  input  logic                     user_rstn,
  input  logic                     user_wreq,
  input  logic [ADDR_WIDTH-1:0]    user_waddr,
  input  logic [31:0]              user_wdata,
  output logic                     user_wack,
  input  logic                     user_rreq,
  input  logic [ADDR_WIDTH-1:0]    user_raddr,
  output logic [31:0]              user_rdata,
  output logic                     user_rack,
  input  logic [NUM_CHAN-1:0]      status_overflow,
  input  logic [NUM_CHAN-1:0]      status_underflow,
  input  logic [NUM_CHAN-1:0]      status_hold_valid,
  input  logic [56*NUM_CHAN-1:0]   status_sample_idx,
  output logic [NUM_CHAN-1:0]      cfg_enable,
  output logic [NUM_CHAN-1:0]      cfg_chan_reset,
  output logic [56*NUM_CHAN-1:0]   cfg_sample_idx,
  output logic [NUM_CHAN-1:0]      cfg_sample_idx_updated,
  output logic [32*NUM_CHAN-1:0]   cfg_decimation_ratio,
  output logic [32*NUM_CHAN-1:0]   cfg_reload_data,
  output logic [NUM_CHAN-1:0]      cfg_reload_valid,
  output logic [NUM_CHAN-1:0]      cfg_reload_last,
  output logic                     irq
);

  localparam int unsigned PW = ADDR_WIDTH - 5;
  localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

  logic [PW-1:0] wpage, rpage;
  logic [4:0]    woff, roff;
  logic [NUM_CHAN-1:0] wsel, rsel, pending;
  logic [NUM_CHAN-1:0][55:0] live;

  logic [NUM_CHAN-1:0] enable_q, enable_d, chan_reset_q, chan_reset_d;
  logic [NUM_CHAN-1:0] sov_q, sov_d, sun_q, sun_d, upd_q, upd_d;
  logic [NUM_CHAN-1:0] rvalid_q, rvalid_d, rlast_q, rlast_d, last_seen_q, last_seen_d;
  logic [NUM_CHAN-1:0] mask_q, mask_d;
  logic [NUM_CHAN-1:0][23:0] shadow_q, shadow_d;
  logic [NUM_CHAN-1:0][55:0] sidx_q, sidx_d;
  logic [NUM_CHAN-1:0][31:0] snap_q, snap_d, dec_q, dec_d, rld_q, rld_d;
  logic [NUM_CHAN-1:0][15:0] cnt_q, cnt_d;
  logic [31:0] scratch_q, scratch_d, rdata_q, rdata_d, rword;
  logic        wack_q, wack_d, rack_q, rack_d, irq_q, irq_d;

  assign wpage   = user_waddr[ADDR_WIDTH-1:5];
  assign woff    = user_waddr[4:0];
  assign rpage   = user_raddr[ADDR_WIDTH-1:5];
  assign roff    = user_raddr[4:0];
  assign live    = status_sample_idx;
  assign pending = sov_q | sun_q;

  // Channel window selects; page 0 is the global page
  always_comb begin
    wsel = '0;
    rsel = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      wsel[c] = user_wreq && (wpage == PW'(c + 1));
      rsel[c] = user_rreq && (rpage == PW'(c + 1));
    end
  end

  always_comb begin
    enable_d     = enable_q;
    chan_reset_d = chan_reset_q;
    shadow_d     = shadow_q;
    sidx_d       = sidx_q;
    snap_d       = snap_q;
    dec_d        = dec_q;
    rld_d        = rld_q;
    cnt_d        = cnt_q;
    last_seen_d  = last_seen_q;
    mask_d       = mask_q;
    scratch_d    = scratch_q;
    upd_d        = '0;
    rvalid_d     = '0;
    rlast_d      = '0;
    sov_d        = sov_q;
    sun_d        = sun_q;
    rword        = BAD_WORD;
    wack_d       = user_wreq;
    rack_d       = user_rreq;
    irq_d        = |(pending & mask_q);

    if (user_wreq && wpage == PW'(0)) begin
      case (woff)
        5'd2:    mask_d    = user_wdata[NUM_CHAN-1:0];
        5'd4:    scratch_d = user_wdata;
        default: ;
      endcase
    end

    if (rpage == PW'(0)) begin
      case (roff)
        5'd0:    rword = {BLK_ID, BLK_VER};
        5'd1:    rword = 32'(NUM_CHAN);
        5'd2:    rword = 32'(mask_q);
        5'd3:    rword = 32'(pending);
        5'd4:    rword = scratch_q;
        default: rword = BAD_WORD;
      endcase
    end

    for (int c = 0; c < NUM_CHAN; c++) begin
      // Event set beats a coincident write-1-clear
      sov_d[c] = status_overflow[c]  | (sov_q[c] & ~(wsel[c] && woff == 5'd1 && user_wdata[0]));
      sun_d[c] = status_underflow[c] | (sun_q[c] & ~(wsel[c] && woff == 5'd1 && user_wdata[1]));

      if (wsel[c]) begin
        case (woff)
          5'd0: begin
            enable_d[c]     = user_wdata[0];
            chan_reset_d[c] = user_wdata[1];
          end
          5'd2: shadow_d[c] = user_wdata[23:0];
          5'd3: begin
            sidx_d[c] = {shadow_q[c], user_wdata};
            upd_d[c]  = 1'b1;
          end
          5'd6: dec_d[c] = user_wdata;
          5'd7, 5'd8: begin
            rld_d[c]       = user_wdata;
            rvalid_d[c]    = 1'b1;
            rlast_d[c]     = (woff == 5'd8);
            last_seen_d[c] = (woff == 5'd8);
            // First word after a last restarts the count at 1
            if (last_seen_q[c])            cnt_d[c] = 16'd1;
            else if (cnt_q[c] != 16'hFFFF) cnt_d[c] = cnt_q[c] + 16'd1;
          end
          default: ;
        endcase
      end

      if (rsel[c]) begin
        case (roff)
          5'd0:       rword = {30'b0, chan_reset_q[c], enable_q[c]};
          5'd1:       rword = {29'b0, status_hold_valid[c], sun_q[c], sov_q[c]};
          5'd2:       rword = {8'b0, shadow_q[c]};
          5'd3:       rword = sidx_q[c][31:0];
          5'd4: begin
            rword     = {8'b0, live[c][55:32]};
            snap_d[c] = live[c][31:0];
          end
          5'd5:       rword = snap_q[c];
          5'd6:       rword = dec_q[c];
          5'd7, 5'd8: rword = 32'h0;
          5'd9:       rword = {16'b0, cnt_q[c]};
          default:    rword = BAD_WORD;
        endcase
      end
    end

    rdata_d = user_rreq ? rword : rdata_q;
  end

  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      enable_q     <= '0;
      chan_reset_q <= '1;
      shadow_q     <= '0;
      sidx_q       <= '0;
      snap_q       <= '0;
      for (int c = 0; c < NUM_CHAN; c++) dec_q[c] <= 32'd1;
      rld_q        <= '0;
      cnt_q        <= '0;
      last_seen_q  <= '0;
      mask_q       <= '0;
      scratch_q    <= '0;
      upd_q        <= '0;
      rvalid_q     <= '0;
      rlast_q      <= '0;
      sov_q        <= '0;
      sun_q        <= '0;
      rdata_q      <= '0;
      wack_q       <= 1'b0;
      rack_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      chan_reset_q <= chan_reset_d;
      shadow_q     <= shadow_d;
      sidx_q       <= sidx_d;
      snap_q       <= snap_d;
      dec_q        <= dec_d;
      rld_q        <= rld_d;
      cnt_q        <= cnt_d;
      last_seen_q  <= last_seen_d;
      mask_q       <= mask_d;
      scratch_q    <= scratch_d;
      upd_q        <= upd_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      sov_q        <= sov_d;
      sun_q        <= sun_d;
      rdata_q      <= rdata_d;
      wack_q       <= wack_d;
      rack_q       <= rack_d;
      irq_q        <= irq_d;
    end
  end

  assign user_wack              = wack_q;
  assign user_rack              = rack_q;
  assign user_rdata             = rdata_q;
  assign cfg_enable             = enable_q;
  assign cfg_chan_reset         = chan_reset_q;
  assign cfg_sample_idx         = sidx_q;
  assign cfg_sample_idx_updated = upd_q;
  assign cfg_decimation_ratio   = dec_q;
  assign cfg_reload_data        = rld_q;
  assign cfg_reload_valid       = rvalid_q;
  assign cfg_reload_last        = rlast_q;
  assign irq                    = irq_q;

endmodule

// File: tb/tb_multi_chan_block_regs.sv
// Directed bench for multi_chan_block_regs: register table plus multi-cycle corner sequences.
module tb_multi_chan_block_regs;

  localparam int unsigned NC = 4;

  logic              user_clk, user_rstn;
  logic              user_wreq, user_rreq, user_wack, user_rack;
  logic [8:0]        user_waddr, user_raddr;
  logic [31:0]       user_wdata, user_rdata;
  logic [NC-1:0]     status_overflow, status_underflow, status_hold_valid;
  logic [56*NC-1:0]  status_sample_idx;
  logic [NC-1:0]     cfg_enable, cfg_chan_reset, cfg_sample_idx_updated;
  logic [NC-1:0]     cfg_reload_valid, cfg_reload_last;
  logic [56*NC-1:0]  cfg_sample_idx;
  logic [32*NC-1:0]  cfg_decimation_ratio, cfg_reload_data;
  logic              irq;

  int checks = 0;
  int errors = 0;

  multi_chan_block_regs #(.NUM_CHAN(NC)) dut (
    .user_clk(user_clk), .user_rstn(user_rstn),
    .user_wreq(user_wreq), .user_waddr(user_waddr), .user_wdata(user_wdata),
    .user_wack(user_wack),
    .user_rreq(user_rreq), .user_raddr(user_raddr),
    .user_rdata(user_rdata), .user_rack(user_rack),
    .status_overflow(status_overflow), .status_underflow(status_underflow),
    .status_hold_valid(status_hold_valid), .status_sample_idx(status_sample_idx),
    .cfg_enable(cfg_enable), .cfg_chan_reset(cfg_chan_reset),
    .cfg_sample_idx(cfg_sample_idx), .cfg_sample_idx_updated(cfg_sample_idx_updated),
    .cfg_decimation_ratio(cfg_decimation_ratio), .cfg_reload_data(cfg_reload_data),
    .cfg_reload_valid(cfg_reload_valid), .cfg_reload_last(cfg_reload_last),
    .irq(irq)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  typedef struct {
    logic        is_wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    @(negedge user_clk);
    user_wreq = 1'b1; user_waddr = a; user_wdata = d;
    @(posedge user_clk); #1;
    user_wreq = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, output logic [31:0] d);
    @(negedge user_clk);
    user_rreq = 1'b1; user_raddr = a;
    @(posedge user_clk); #1;
    user_rreq = 1'b0;
    d = user_rdata;
  endtask

  logic [31:0] r;

  initial begin
    tbl[0]  = '{1'b0, 9'h000, 32'h0,        32'h00030001};
    tbl[1]  = '{1'b0, 9'h001, 32'h0,        32'd4};
    tbl[2]  = '{1'b0, 9'h020, 32'h0,        32'h2};
    tbl[3]  = '{1'b1, 9'h004, 32'hCAFEF00D, 32'h1};
    tbl[4]  = '{1'b0, 9'h004, 32'h0,        32'hCAFEF00D};
    tbl[5]  = '{1'b1, 9'h002, 32'h5,        32'h1};
    tbl[6]  = '{1'b0, 9'h002, 32'h0,        32'h5};
    tbl[7]  = '{1'b0, 9'h0C0, 32'h0,        32'hDEADBEEF};
    tbl[8]  = '{1'b0, 9'h03F, 32'h0,        32'hDEADBEEF};
    tbl[9]  = '{1'b0, 9'h006, 32'h0,        32'hDEADBEEF};
    tbl[10] = '{1'b1, 9'h0C0, 32'h11111111, 32'h1};
    tbl[11] = '{1'b1, 9'h03F, 32'hFFFFFFFF, 32'h1};
    tbl[12] = '{1'b0, 9'h004, 32'h0,        32'hCAFEF00D};
    tbl[13] = '{1'b0, 9'h020, 32'h0,        32'h2};
    tbl[14] = '{1'b1, 9'h046, 32'h10,       32'h1};
    tbl[15] = '{1'b0, 9'h046, 32'h0,        32'h10};
    tbl[16] = '{1'b0, 9'h026, 32'h0,        32'h1};
    tbl[17] = '{1'b1, 9'h002, 32'h0,        32'h1};
    tbl[18] = '{1'b1, 9'h020, 32'h1,        32'h1};
    tbl[19] = '{1'b0, 9'h020, 32'h0,        32'h1};

    user_rstn = 1'b0; user_wreq = 1'b0; user_rreq = 1'b0;
    user_waddr = '0; user_raddr = '0; user_wdata = '0;
    status_overflow = '0; status_underflow = '0; status_hold_valid = '0;
    status_sample_idx = '0;
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    user_rstn = 1'b1;

    // Reset state
    chk("rst_chan_reset", 64'(cfg_chan_reset), 64'hF);
    chk("rst_enable", 64'(cfg_enable), 64'h0);
    for (int c = 0; c < NC; c++)
      chk($sformatf("rst_dec%0d", c), 64'(cfg_decimation_ratio[c*32 +: 32]), 64'd1);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_acks", {62'b0, user_wack, user_rack}, 64'h0);
    chk("rst_rdata", 64'(user_rdata), 64'h0);

    // Register table
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].is_wr) begin
        wr(tbl[i].addr, tbl[i].data);
        chk($sformatf("vec%0d_wack", i), 64'(user_wack), 64'(tbl[i].exp));
      end else begin
        rd(tbl[i].addr, r);
        chk($sformatf("vec%0d_rdata", i), 64'(r), 64'(tbl[i].exp));
        chk($sformatf("vec%0d_rack", i), 64'(user_rack), 64'h1);
      end
    end
    chk("enable_out", 64'(cfg_enable), 64'h1);
    chk("chan_reset_out", 64'(cfg_chan_reset), 64'hE);

    // Atomic sample index on channel 2
    wr(9'h062, 32'h00ABCDEF);
    chk("sidx_shadow_only", 64'(cfg_sample_idx[2*56 +: 56]), 64'h0);
    chk("sidx_no_upd", 64'(cfg_sample_idx_updated), 64'h0);
    wr(9'h063, 32'h12345678);
    chk("sidx_upd", 64'(cfg_sample_idx_updated), 64'h4);
    chk("sidx_ch2", 64'(cfg_sample_idx[2*56 +: 56]), 64'h00ABCDEF12345678);
    for (int c = 0; c < NC; c++)
      if (c != 2) chk($sformatf("sidx_ch%0d_kept", c), 64'(cfg_sample_idx[c*56 +: 56]), 64'h0);
    @(posedge user_clk); #1;
    chk("sidx_upd_1cyc", 64'(cfg_sample_idx_updated), 64'h0);
    rd(9'h063, r); chk("sidx_lo_rd", 64'(r), 64'h12345678);
    rd(9'h062, r); chk("sidx_hi_rd", 64'(r), 64'h00ABCDEF);

    // Sticky status and irq on channel 1
    @(negedge user_clk);
    status_overflow = 4'b0010; status_hold_valid = 4'b0010;
    @(negedge user_clk);
    status_overflow = '0;
    chk("irq_masked", 64'(irq), 64'h0);
    wr(9'h002, 32'h2);
    @(posedge user_clk); #1;
    chk("irq_set", 64'(irq), 64'h1);
    rd(9'h003, r); chk("pending", 64'(r), 64'h2);
    rd(9'h041, r); chk("status1", 64'(r), 64'h5);
    @(negedge user_clk);
    user_wreq = 1'b1; user_waddr = 9'h041; user_wdata = 32'h1; status_overflow = 4'b0010;
    @(posedge user_clk); #1;
    user_wreq = 1'b0; status_overflow = '0;
    rd(9'h041, r); chk("set_wins", 64'(r), 64'h5);
    chk("irq_held", 64'(irq), 64'h1);
    wr(9'h041, 32'h1);
    rd(9'h041, r); chk("w1c_ov", 64'(r), 64'h4);
    chk("irq_clr", 64'(irq), 64'h0);
    @(negedge user_clk); status_underflow = 4'b0010;
    @(negedge user_clk); status_underflow = '0;
    rd(9'h041, r); chk("sticky_un", 64'(r), 64'h6);
    wr(9'h041, 32'h2);
    rd(9'h041, r); chk("w1c_un", 64'(r), 64'h4);
    status_hold_valid = '0;

    // Live index snapshot on channel 0
    status_sample_idx[0 +: 56] = 56'h1_0000_0005;
    rd(9'h024, r); chk("live_hi", 64'(r), 64'h1);
    status_sample_idx[0 +: 56] = 56'h2_0000_0009;
    rd(9'h025, r); chk("snap_lo", 64'(r), 64'h5);
    rd(9'h024, r); chk("live_hi2", 64'(r), 64'h2);
    rd(9'h025, r); chk("snap_lo2", 64'(r), 64'h9);

    // Reload strobes and word counter on channel 3
    for (int k = 1; k <= 4; k++) begin
      wr((k == 3) ? 9'h088 : 9'h087, 32'(k));
      chk($sformatf("rld%0d_valid", k), 64'(cfg_reload_valid), 64'h8);
      chk($sformatf("rld%0d_last", k), 64'(cfg_reload_last), (k == 3) ? 64'h8 : 64'h0);
      chk($sformatf("rld%0d_data", k), 64'(cfg_reload_data[3*32 +: 32]), 64'(k));
      if (k == 3) begin
        rd(9'h089, r); chk("rld_cnt3", 64'(r), 64'd3);
      end
    end
    rd(9'h089, r); chk("rld_cnt_restart", 64'(r), 64'd1);
    chk("rld_valid_drop", 64'(cfg_reload_valid), 64'h0);

    // Same-cycle read and write: read sees pre-write contents
    @(negedge user_clk);
    user_wreq = 1'b1; user_waddr = 9'h004; user_wdata = 32'h000055AA;
    user_rreq = 1'b1; user_raddr = 9'h004;
    @(posedge user_clk); #1;
    user_wreq = 1'b0; user_rreq = 1'b0;
    chk("rw_old", 64'(user_rdata), 64'hCAFEF00D);
    chk("rw_wack", 64'(user_wack), 64'h1);
    rd(9'h004, r); chk("rw_new", 64'(r), 64'h000055AA);

    // Asynchronous reset mid-strobe
    @(negedge user_clk);
    user_wreq = 1'b1; user_waddr = 9'h087; user_wdata = 32'h5;
    @(posedge user_clk); #1;
    user_wreq = 1'b0;
    chk("pre_rst_valid", 64'(cfg_reload_valid), 64'h8);
    #1 user_rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(cfg_reload_valid), 64'h0);
    chk("arst_chan_reset", 64'(cfg_chan_reset), 64'hF);
    chk("arst_dec1", 64'(cfg_decimation_ratio[32 +: 32]), 64'd1);
    chk("arst_reload_data", 64'(cfg_reload_data[3*32 +: 32]), 64'h0);
    chk("arst_sidx", 64'(cfg_sample_idx[2*56 +: 56]), 64'h0);
    @(negedge user_clk);
    user_rstn = 1'b1;
    rd(9'h004, r); chk("post_rst_scratch", 64'(r), 64'h0);
    rd(9'h089, r); chk("post_rst_cnt", 64'(r), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
